layer_sequencer: RTL

//  Central run-control FSM for the cube inference network. Sequences the input buffer,
//  the shared cnn_layer (conv passes 0-3 and the affine pass), elu_layer and comp_layer.

---
 rtl/layer_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Run-control FSM for the cube inference network. Walks the datapath through
//   BUFFER -> (CNN pass n -> ELU) x4 -> CNN affine pass -> COMP -> FIN. It drives
//   one load level per stage and waits for that stage's valid flag. A watchdog
//   puts the sequencer in ERR when any stage stalls too long.
//
// Parameters
//   BUF_CYCLES  cycles spent in BUFFER (>= 1)
//   TIMEOUT     max cycles in a wait state before ERR; 0 disables the watchdog
//   CNT_W       dwell/watchdog counter width (must hold TIMEOUT-1 and BUF_CYCLES-1)
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   run                 start request level, sampled in IDLE / FIN / ERR
//   abort               forces a return to IDLE from any state
//   cnn_valid           cnn_layer pass complete
//   elu_valid           elu_layer complete
//   comp_valid          comp_layer complete
//   buf_load            high in BUFFER
//   cnn_load            high in CNN (all five passes)
//   elu_load            high in ELU
//   comp_load           high in COMP
//   cs[3:0]             layer code: 2+pass in CNN, otherwise the state code
//   pass[2:0]           cnn pass index, 0-3 conv, 4 affine
//   busy                high outside IDLE / FIN / ERR
//   valid               high in FIN
//   err                 high in ERR
module layer_sequencer #(
  parameter int BUF_CYCLES = 1,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       abort,
  input  logic       cnn_valid,
  input  logic       elu_valid,
  input  logic       comp_valid,
  output logic       buf_load,
  output logic       cnn_load,
  output logic       elu_load,
  output logic       comp_load,
  output logic [3:0] cs,
  output logic [2:0] pass,
  output logic       busy,
  output logic       valid,
  output logic       err
);

  // Enum values equal the external layer codes, so cs is the state itself
  // everywhere except CNN, where it is 2+pass.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_BUFFER = 4'd1,
    S_CNN    = 4'd2,
    S_ELU    = 4'd7,
    S_COMP   = 4'd8,
    S_FIN    = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  localparam logic [2:0]       LAST_PASS = 3'd4;
  localparam bit               WD_EN     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] BUF_LAST  = CNT_W'((BUF_CYCLES > 0) ? BUF_CYCLES - 1 : 0);

  state_t           state, state_nx;
  logic [2:0]       pass_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             wd_hit;
  logic [3:0]       cs_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pass      <= '0;
      cnt       <= '0;
      buf_load  <= 1'b0;
      cnn_load  <= 1'b0;
      elu_load  <= 1'b0;
      comp_load <= 1'b0;
      cs        <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      pass      <= pass_nx;
      cnt       <= cnt_nx;
      // Outputs are decoded from the next state and registered, so they
      // change on the same edge as the state register.
      buf_load  <= (state_nx == S_BUFFER);
      cnn_load  <= (state_nx == S_CNN);
      elu_load  <= (state_nx == S_ELU);
      comp_load <= (state_nx == S_COMP);
      cs        <= cs_nx;
      busy      <= (state_nx == S_BUFFER) || (state_nx == S_CNN) ||
                   (state_nx == S_ELU)    || (state_nx == S_COMP);
      valid     <= (state_nx == S_FIN);
      err       <= (state_nx == S_ERR);
    end
  end

  // The watchdog fires on the last permitted cycle only if the awaited valid
  // is still low; each wait state checks its valid first, so valid wins a tie.
  assign wd_hit = WD_EN && (cnt == WD_LAST);

  always_comb begin
    state_nx = state;
    pass_nx  = pass;
    unique case (state)
      S_IDLE: begin
        pass_nx = '0;
        if (run) state_nx = S_BUFFER;
      end
      S_BUFFER: begin
        if (cnt == BUF_LAST) begin
          state_nx = S_CNN;
          pass_nx  = '0;
        end
      end
      S_CNN: begin
        if (cnn_valid) state_nx = (pass >= LAST_PASS) ? S_COMP : S_ELU;
        else if (wd_hit) state_nx = S_ERR;
      end
      S_ELU: begin
        if (elu_valid) begin
          state_nx = S_CNN;
          pass_nx  = (pass >= LAST_PASS) ? LAST_PASS : pass + 3'd1;
        end else if (wd_hit) begin
          state_nx = S_ERR;
        end
      end
      S_COMP: begin
        if (comp_valid) state_nx = S_FIN;
        else if (wd_hit) state_nx = S_ERR;
      end
      S_FIN, S_ERR: begin
        if (!run) begin
          state_nx = S_IDLE;
          pass_nx  = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        pass_nx  = '0;
      end
    endcase

    if (abort) begin
      state_nx = S_IDLE;
      pass_nx  = '0;
    end
  end

  // The dwell counter restarts on every state change. BUFFER reuses it to
  // time its fixed length; the wait states use it as the watchdog.
  always_comb begin
    cnt_nx = '0;
    if (state_nx == state &&
        (state == S_BUFFER || state == S_CNN || state == S_ELU || state == S_COMP))
      cnt_nx = cnt + 1'b1;
  end

  always_comb begin
    cs_nx = 4'(state_nx);
    if (state_nx == S_CNN) cs_nx = 4'd2 + {1'b0, pass_nx};
  end

endmodule
